// File: rtl/l15_pkg.sv
// Shared definitions for the L1.5 responder model.
// Holds the transducer request/return type encodings, the access size
// encoding, the responder FSM state type and the store byte-lane helper.
package l15_pkg;

  // Request types driven by the core-side transducer
  localparam logic [4:0] LOAD_RQ  = 5'd0;
  localparam logic [4:0] STORE_RQ = 5'd1;
  localparam logic [4:0] IMISS_RQ = 5'd16;

  // Return types sent back with the response
  localparam logic [3:0] LOAD_RET  = 4'd0;
  localparam logic [3:0] IFILL_RET = 4'd1;
  localparam logic [3:0] ST_ACK    = 4'd4;

  // Access size encoding (bytes = 1 << size)
  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } l15_state_e;

  // Little-endian byte-lane mask for a store. Lanes past the end of the
  // 64-bit word fall off the top of the 8-bit result, which is how
  // misaligned stores get clipped to the addressed word.
  function automatic logic [7:0] store_mask(input logic [2:0] size,
                                            input logic [2:0] offset);
    logic [3:0] nbytes;
    logic [7:0] lanes;
    if (size > SIZE_8B) begin
      lanes = 8'h00;
    end else begin
      nbytes = 4'd1 << size[1:0];
      lanes  = (8'hFF >> (4'd8 - nbytes)) << offset;
    end
    return lanes;
  endfunction

endpackage

// File: rtl/l15_resp_mem.sv
// One bank of the responder backing store: synchronous single-port RAM,
// 64-bit words, per-byte write enables and a registered read.
// Ports:
//   clk      clock
//   i_en     access strobe; a read is captured on every enabled edge
//   i_be     byte write enables (qualified by i_en)
//   i_addr   row address
//   i_wdata  write data, byte lanes aligned with i_be
//   o_rdata  registered read data (pre-write contents), held until the
//            next enabled access
// BANK selects the interleaved word set held by this bank (0 even, 1 odd).
module l15_resp_mem
  import l15_pkg::*;
#(
  parameter int    ROWS      = 2048,
  parameter int    BANK      = 0,
  parameter string INIT_FILE = "",
  localparam int   RAW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic           clk,
  input  logic           i_en,
  input  logic [7:0]     i_be,
  input  logic [RAW-1:0] i_addr,
  input  logic [63:0]    i_wdata,
  output logic [63:0]    o_rdata
);

  logic [63:0] r_mem [ROWS];
  logic [63:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 8; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/l15_responder.sv
// Target-side stand-in for the L1.5 cache on the transducer interface.
// Accepts one request at a time, performs the memory access on the accept
// edge, pulses ack for one cycle, waits RESP_LATENCY idle cycles and then
// presents the response until the requester consumes it.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   transducer_l15_rqtype/size    request type and access size
//   transducer_l15_address        byte address (wraps modulo memory size)
//   transducer_l15_data           store data, lanes aligned to address[2:0]
//   transducer_l15_val            request valid, held until acked
//   transducer_l15_req_ack        requester consumed the response
//   l15_transducer_ack            request accepted (one-cycle pulse)
//   l15_transducer_header_ack     same pulse as l15_transducer_ack
//   l15_transducer_val            response valid
//   l15_transducer_data_0/_1      response data, low/high 8 bytes
//   l15_transducer_returntype     response type
module l15_responder
  import l15_pkg::*;
#(
  parameter int    MEM_WORDS    = 4096,
  parameter int    RESP_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  transducer_l15_rqtype,
  input  logic [2:0]  transducer_l15_size,
  input  logic [39:0] transducer_l15_address,
  input  logic [63:0] transducer_l15_data,
  input  logic        transducer_l15_val,
  input  logic        transducer_l15_req_ack,
  output logic        l15_transducer_ack,
  output logic        l15_transducer_header_ack,
  output logic        l15_transducer_val,
  output logic [63:0] l15_transducer_data_0,
  output logic [63:0] l15_transducer_data_1,
  output logic [3:0]  l15_transducer_returntype
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int RW = AW - 1;
  localparam int CW = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;

  l15_state_e  r_state;
  logic [CW-1:0] r_cnt;
  logic        r_ack;
  logic        r_val;
  logic [63:0] r_data0;
  logic [63:0] r_data1;
  logic [3:0]  r_rettype;
  logic [4:0]  r_rqtype;
  logic        r_odd;

  logic          w_accept;
  logic          w_bank;
  logic [RW-1:0] w_row;
  logic [7:0]    w_mask;
  logic [7:0]    w_be_even;
  logic [7:0]    w_be_odd;
  logic [63:0]   w_rd_even;
  logic [63:0]   w_rd_odd;
  logic [63:0]   w_d0;
  logic [63:0]   w_d1;
  logic [3:0]    w_rt;
  logic          w_unused;

  // Word index LSB picks the bank, so an IFILL pair sits on one row of
  // both banks and is read in a single cycle.
  assign w_accept = !rst && (r_state == S_IDLE) && transducer_l15_val;
  assign w_bank   = transducer_l15_address[3];
  assign w_row    = transducer_l15_address[4 +: RW];
  assign w_mask   = (transducer_l15_rqtype == STORE_RQ)
                  ? store_mask(transducer_l15_size, transducer_l15_address[2:0])
                  : 8'h00;
  assign w_be_even = w_bank ? 8'h00 : w_mask;
  assign w_be_odd  = w_bank ? w_mask : 8'h00;

  // Address bits above the memory size are ignored (addresses wrap).
  assign w_unused = ^transducer_l15_address[39:3+AW];

  l15_resp_mem #(
    .ROWS      (MEM_WORDS / 2),
    .BANK      (0),
    .INIT_FILE (INIT_FILE)
  ) u_even (
    .clk     (clk),
    .i_en    (w_accept),
    .i_be    (w_be_even),
    .i_addr  (w_row),
    .i_wdata (transducer_l15_data),
    .o_rdata (w_rd_even)
  );

  l15_resp_mem #(
    .ROWS      (MEM_WORDS / 2),
    .BANK      (1),
    .INIT_FILE (INIT_FILE)
  ) u_odd (
    .clk     (clk),
    .i_en    (w_accept),
    .i_be    (w_be_odd),
    .i_addr  (w_row),
    .i_wdata (transducer_l15_data),
    .o_rdata (w_rd_odd)
  );

  // Bank read data is held from the accept edge until the next access, so
  // the response can be formed from it whenever the wait period ends.
  always_comb begin
    w_d0 = 64'd0;
    w_d1 = 64'd0;
    w_rt = LOAD_RET;
    case (r_rqtype)
      IMISS_RQ: begin
        w_d0 = w_rd_even;
        w_d1 = w_rd_odd;
        w_rt = IFILL_RET;
      end
      LOAD_RQ: begin
        w_d0 = r_odd ? w_rd_odd : w_rd_even;
        w_d1 = r_odd ? w_rd_odd : w_rd_even;
        w_rt = LOAD_RET;
      end
      STORE_RQ: w_rt = ST_ACK;
      default:  w_rt = LOAD_RET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_val     <= 1'b0;
      r_data0   <= 64'd0;
      r_data1   <= 64'd0;
      r_rettype <= LOAD_RET;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (transducer_l15_val) begin
            r_rqtype <= transducer_l15_rqtype;
            r_odd    <= w_bank;
            r_ack    <= 1'b1;
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack <= 1'b0;
          if (RESP_LATENCY == 0) begin
            r_state   <= S_RESP;
            r_val     <= 1'b1;
            r_data0   <= w_d0;
            r_data1   <= w_d1;
            r_rettype <= w_rt;
          end else begin
            r_cnt   <= CW'(RESP_LATENCY);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_cnt     <= '0;
            r_state   <= S_RESP;
            r_val     <= 1'b1;
            r_data0   <= w_d0;
            r_data1   <= w_d1;
            r_rettype <= w_rt;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (transducer_l15_req_ack) begin
            r_state   <= S_IDLE;
            r_val     <= 1'b0;
            r_data0   <= 64'd0;
            r_data1   <= 64'd0;
            r_rettype <= LOAD_RET;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign l15_transducer_ack        = r_ack;
  assign l15_transducer_header_ack = r_ack;
  assign l15_transducer_val        = r_val;
  assign l15_transducer_data_0     = r_data0;
  assign l15_transducer_data_1     = r_data1;
  assign l15_transducer_returntype = r_rettype;

endmodule

// File: tb/tb_l15_responder.sv
// Bench for l15_responder: byte-array memory model with a transaction-level
// timing model (ack cycle, response window) checked every cycle, plus
// directed literal checks and a zero-latency instance for timing.
module tb_l15_responder;
  import l15_pkg::*;

  localparam int MW  = 128;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rqtype;
  logic [2:0]  size;
  logic [39:0] addr;
  logic [63:0] wdata;
  logic        val, req_ack;
  logic        ack, hack, rval;
  logic [63:0] d0, d1;
  logic [3:0]  rt;

  logic [4:0]  z_rqtype;
  logic [2:0]  z_size;
  logic [39:0] z_addr;
  logic [63:0] z_wdata;
  logic        z_val, z_req_ack;
  logic        z_ack, z_hack, z_rval;
  logic [63:0] z_d0, z_d1;
  logic [3:0]  z_rt;

  l15_responder #(.MEM_WORDS(MW), .RESP_LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .transducer_l15_rqtype(rqtype), .transducer_l15_size(size),
    .transducer_l15_address(addr), .transducer_l15_data(wdata),
    .transducer_l15_val(val), .transducer_l15_req_ack(req_ack),
    .l15_transducer_ack(ack), .l15_transducer_header_ack(hack),
    .l15_transducer_val(rval), .l15_transducer_data_0(d0),
    .l15_transducer_data_1(d1), .l15_transducer_returntype(rt)
  );

  l15_responder #(.MEM_WORDS(MW), .RESP_LATENCY(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst),
    .transducer_l15_rqtype(z_rqtype), .transducer_l15_size(z_size),
    .transducer_l15_address(z_addr), .transducer_l15_data(z_wdata),
    .transducer_l15_val(z_val), .transducer_l15_req_ack(z_req_ack),
    .l15_transducer_ack(z_ack), .l15_transducer_header_ack(z_hack),
    .l15_transducer_val(z_rval), .l15_transducer_data_0(z_d0),
    .l15_transducer_data_1(z_d1), .l15_transducer_returntype(z_rt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mbytes [MW][8];
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_ack_c = 0;
  logic [63:0] m_d0, m_d1;
  logic [3:0]  m_rt;
  bit          chk_en = 0;

  function automatic logic [63:0] mword(input int w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = mbytes[w][b];
    return r;
  endfunction

  always @(posedge clk) begin
    int w, off, nb;
    cyc++;
    if (rst) begin
      m_busy = 0;
    end else if (m_busy) begin
      if ((cyc - 1) >= (m_ack_c + 1 + LAT) && req_ack) m_busy = 0;
    end else if (val) begin
      w = int'(addr[9:3]);
      m_busy = 1;
      m_ack_c = cyc;
      m_d0 = 64'd0;
      m_d1 = 64'd0;
      m_rt = 4'd0;
      if (rqtype == 5'd0) begin
        m_d0 = mword(w);
        m_d1 = m_d0;
      end else if (rqtype == 5'd16) begin
        m_d0 = mword(w & ~1);
        m_d1 = mword(w | 1);
        m_rt = 4'd1;
      end else if (rqtype == 5'd1) begin
        m_rt = 4'd4;
        off = int'(addr[2:0]);
        if (size <= 3) begin
          nb = 1 << size;
          for (int b = off; b < off + nb && b < 8; b++) mbytes[w][b] = wdata[b*8 +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_ack, e_val;
    logic [63:0] e_d0, e_d1;
    logic [3:0] e_rt;
    if (chk_en) begin
      e_ack = m_busy && (cyc == m_ack_c);
      e_val = m_busy && (cyc >= m_ack_c + 1 + LAT);
      e_d0  = e_val ? m_d0 : 64'd0;
      e_d1  = e_val ? m_d1 : 64'd0;
      e_rt  = e_val ? m_rt : 4'd0;
      vectors++;
      if (ack !== e_ack || hack !== e_ack || rval !== e_val ||
          d0 !== e_d0 || d1 !== e_d1 || rt !== e_rt) begin
        miscompares++;
        $display("FAIL cycle %0d: got ack=%b hack=%b val=%b d0=%h d1=%h rt=%0d expected ack=%b val=%b d0=%h d1=%h rt=%0d",
                 cyc, ack, hack, rval, d0, d1, rt, e_ack, e_val, e_d0, e_d1, e_rt);
      end
    end
  end

  // ---------------- stimulus ----------------
  int ra_mode = 1;   // 0 random, 1 always consume, 2 never consume
  initial forever begin
    @(posedge clk);
    #1;
    case (ra_mode)
      0:       req_ack = ($urandom % 3) != 0;
      1:       req_ack = 1'b1;
      default: req_ack = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] t, input logic [2:0] s, input logic [39:0] a,
                       input logic [63:0] d, output int ack_cyc);
    int n;
    n = 0;
    rqtype = t; size = s; addr = a; wdata = d; val = 1'b1;
    do begin tick(); n++; end while (ack !== 1'b1 && n < 200);
    if (ack !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout: ack=%b after %0d cycles, expected 1", ack, n);
    end
    ack_cyc = cyc;
    val = 1'b0;
  endtask

  task automatic wait_resp(output logic [63:0] o0, output logic [63:0] o1,
                           output logic [3:0] ort, output int vc);
    int n;
    n = 0;
    while (rval !== 1'b1 && n < 200) begin tick(); n++; end
    if (rval !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: val=%b after %0d cycles, expected 1", rval, n);
    end
    o0 = d0; o1 = d1; ort = rt; vc = cyc;
  endtask

  initial begin
    int kc, vc, dummy;
    int acks[$];
    int vals[$];
    logic [63:0] r0, r1;
    logic [3:0]  rrt;
    logic [4:0]  t;

    rst = 1'b1; val = 1'b0; rqtype = '0; size = '0; addr = '0; wdata = '0;
    z_val = 1'b0; z_rqtype = '0; z_size = '0; z_addr = '0; z_wdata = '0; z_req_ack = 1'b1;
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_hack", hack, 0);
    chk("rst_val", rval, 0);
    chk("rst_d0", d0, 0);
    chk("rst_d1", d1, 0);
    chk("rst_rt", rt, 0);
    chk("rst_z_val", z_rval, 0);
    rst = 1'b0;
    chk_en = 1;

    // zero-latency instance, req_ack tied high, two requests back to back
    z_rqtype = STORE_RQ; z_size = 3'd3; z_addr = 40'h8; z_wdata = 64'h55; z_val = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (z_hack !== z_ack) chk("lat0_hack", z_hack, z_ack);
      if (z_ack === 1'b1) acks.push_back(cyc);
      if (z_rval === 1'b1) begin
        vals.push_back(cyc);
        chk("lat0_rt", z_rt, 4'd4);
      end
      if (acks.size() == 2 && z_ack === 1'b1) z_val = 1'b0;
    end
    chk("lat0_nacks", acks.size(), 2);
    chk("lat0_nvals", vals.size(), 2);
    if (acks.size() >= 2 && vals.size() >= 2) begin
      chk("lat0_val_k1", vals[0] - acks[0], 1);
      chk("lat0_next_ack_k3", acks[1] - acks[0], 3);
      chk("lat0_val2", vals[1] - acks[1], 1);
    end

    // fill every model/DUT word with known data (random high address bits)
    for (int w = 0; w < MW; w++)
      issue(STORE_RQ, 3'd3, {25'($urandom), 7'(w), 3'b000}, {$urandom, $urandom}, dummy);

    // instruction fill of a 16-byte pair
    issue(STORE_RQ, 3'd3, 40'h100, 64'h1111, dummy);
    issue(STORE_RQ, 3'd3, 40'h108, 64'h2222, dummy);
    issue(IMISS_RQ, 3'd0, 40'h100, 64'h0, kc);
    tick();
    chk("ifill_ack_pulse", ack, 0);
    wait_resp(r0, r1, rrt, vc);
    chk("ifill_latency", 64'(vc - kc), 3);
    chk("ifill_d0", r0, 64'h1111);
    chk("ifill_d1", r1, 64'h2222);
    chk("ifill_rt", rrt, 4'd1);

    // partial store then load of the same word
    issue(STORE_RQ, 3'd3, 40'h200, 64'h0123456789ABCDEF, dummy);
    issue(STORE_RQ, 3'd2, 40'h204, 64'hAABBCCDD_00000000, dummy);
    wait_resp(r0, r1, rrt, vc);
    chk("store_rt", rrt, 4'd4);
    chk("store_d0", r0, 64'd0);
    issue(LOAD_RQ, 3'd3, 40'h200, 64'h0, dummy);
    wait_resp(r0, r1, rrt, vc);
    chk("load_rt", rrt, 4'd0);
    chk("load_d0", r0, 64'hAABBCCDD89ABCDEF);
    chk("load_d1", r1, 64'hAABBCCDD89ABCDEF);

    // response held while req_ack stays low; a second request waits
    ra_mode = 2;
    issue(LOAD_RQ, 3'd3, 40'h200, 64'h0, dummy);
    wait_resp(r0, r1, rrt, vc);
    rqtype = LOAD_RQ; addr = 40'h100; val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_val", rval, 1);
      chk("hold_d0", d0, 64'hAABBCCDD89ABCDEF);
      chk("hold_no_ack", ack, 0);
    end
    ra_mode = 1;
    issue(LOAD_RQ, 3'd3, 40'h100, 64'h0, dummy);
    wait_resp(r0, r1, rrt, vc);
    chk("second_load_d0", r0, 64'h1111);

    // reset while waiting after a store
    issue(STORE_RQ, 3'd3, 40'h300, 64'hDEADBEEFCAFEF00D, dummy);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_val", rval, 0);
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_d0", d0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_mid_no_resp", rval, 0);
    end
    issue(LOAD_RQ, 3'd3, 40'h300, 64'h0, dummy);
    wait_resp(r0, r1, rrt, vc);
    chk("rst_store_kept", r0, 64'hDEADBEEFCAFEF00D);

    // unknown request type
    issue(5'd7, 3'd3, 40'h200, 64'hFFFF_FFFF_FFFF_FFFF, dummy);
    wait_resp(r0, r1, rrt, vc);
    chk("unk_rt", rrt, 4'd0);
    chk("unk_d0", r0, 64'd0);
    chk("unk_d1", r1, 64'd0);
    issue(LOAD_RQ, 3'd3, 40'h200, 64'h0, dummy);
    wait_resp(r0, r1, rrt, vc);
    chk("unk_mem_unchanged", r0, 64'hAABBCCDD89ABCDEF);

    // randomized traffic with random consumer back-pressure
    ra_mode = 0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom % 8)
        0, 1, 2: t = LOAD_RQ;
        3, 4:    t = STORE_RQ;
        5, 6:    t = IMISS_RQ;
        default: t = 5'($urandom_range(2, 15));
      endcase
      repeat ($urandom % 3) tick();
      issue(t, 3'($urandom), {8'($urandom), 32'($urandom)}, {$urandom, $urandom}, dummy);
    end
    ra_mode = 1;
    for (int n = 0; n < 50 && m_busy; n++) tick();
    tick();
    chk("drain_idle", rval, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
